// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_t;

    localparam logic PAR_MODE_EVEN = 1'b0;
    localparam logic PAR_MODE_ODD  = 1'b1;

    function automatic bit stop_bits_legal(input int n);
        return (n == 1) || (n == 2);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer with selectable reset value
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic sysclk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised oversampling UART receiver with held result
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 in,
    input  logic                 rx_en,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_status,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_M1   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic          PAR_MODE  = (PARITY_ODD != 0) ? PAR_MODE_ODD : PAR_MODE_EVEN;

    if (!stop_bits_legal(STOP_BITS)) begin : g_bad_stop_bits
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end

    uart_rx_state_t       state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 frm_q, frm_d;
    logic                 line_s;
    logic                 char_done;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .sysclk (sysclk),
        .reset  (reset),
        .d      (in),
        .q      (line_s)
    );

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            frm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            frm_q   <= frm_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        frm_d     = frm_q;
        char_done = 1'b0;
        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    if (rx_en && !line_s) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == HALF_M1) begin
                        tick_d = '0;
                        if (line_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            bit_d   = '0;
                            par_d   = 1'b0;
                            frm_d   = 1'b0;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == FULL_M1) begin
                        tick_d  = '0;
                        shreg_d = {line_s, shreg_q[DATA_BITS-1:1]};
                        if (bit_q == LAST_DATA) begin
                            bit_d   = '0;
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (tick_q == FULL_M1) begin
                        tick_d  = '0;
                        par_d   = (((^shreg_q) ^ line_s) != PAR_MODE);
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_q == FULL_M1) begin
                        tick_d = '0;
                        frm_d  = frm_q | ~line_s;
                        // Leave at the last stop sample so a start edge late in the stop bit is seen.
                        if (bit_q == LAST_STOP) begin
                            state_d   = IDLE;
                            bit_d     = '0;
                            char_done = 1'b1;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // An ack coinciding with completion frees the holding slot for the new character.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            rx_data    <= '0;
            rx_status  <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else if (char_done) begin
            if (!rx_status || rx_ack) begin
                rx_data    <= shreg_q;
                frame_err  <= frm_d;
                parity_err <= par_q;
                rx_status  <= 1'b1;
                overrun    <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (rx_ack && rx_status) begin
            rx_status <= 1'b0;
            overrun   <= 1'b0;
        end
    end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver for the peripheral bus, succeeding the fixed 8N1 receiver. It runs entirely on the system clock: bits are sampled on an external oversampling strobe rather than a separate baud clock. Width, oversampling ratio, parity and stop-bit count are parameters. Completed characters, with framing, parity and overrun status, are held for the CPU-side reader until it acknowledges them.

## Interface
- DATA_BITS, 8, data bits per character (5..9)
- OVERSAMPLE, 16, baud_tick strobes per bit period (even, 4..64)
- PARITY_EN, 0, 1 = a parity bit follows the data bits
- PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN = 0)
- STOP_BITS, 1, stop bits checked (1 or 2)

- sysclk  in  1  system clock; all flops clock on its rising edge
- reset  in  1  synchronous, active-low reset
- baud_tick  in  1  one-sysclk strobe at OVERSAMPLE × baud rate
- in  in  1  asynchronous serial line, idle high
- rx_en  in  1  receiver enable
- rx_ack  in  1  one-cycle pulse: reader has consumed rx_data
- rx_data  out  DATA_BITS  last accepted character, LSB = first bit received
- rx_status  out  1  character valid; held until acknowledged
- frame_err  out  1  stop bit(s) low for the held character
- parity_err  out  1  parity mismatch for the held character
- overrun  out  1  sticky: a character was dropped while rx_status = 1

## Operation
- The in line passes through a 2-flop synchronizer; both flops reset to 1. All further logic uses the synchronized value.
- The tick counter and bit counter advance only on cycles where baud_tick = 1.
- FSM states are IDLE, START, DATA, PARITY, STOP.
- IDLE: if rx_en = 1 and the synchronized line = 0 on a tick, go to START and clear the tick counter.
- START: at tick OVERSAMPLE/2 − 1 (mid start bit), resample the line.
  - Line = 1: false start, return to IDLE.
  - Line = 0: go to DATA and clear the tick counter.
- DATA: sample each bit at tick OVERSAMPLE − 1 from the previous sample point. Shift bits in LSB first. After DATA_BITS samples, go to PARITY if PARITY_EN = 1, otherwise go to STOP.
- PARITY: sample one bit. parity_err_next = (XOR of data bits ^ sampled bit) ≠ PARITY_ODD.
- STOP: sample STOP_BITS bits. frame_err_next = 1 if any stop sample is 0. Return to IDLE immediately after the last stop sample, so a start edge in the second half of the stop bit is caught.
- Character completion, on the cycle after the last stop sample:
  - rx_status = 0, or rx_ack = 1 in the same cycle: load rx_data, frame_err and parity_err, and set rx_status = 1.
  - rx_status = 1 and rx_ack = 0: discard the new character, set overrun = 1, and leave held data and flags unchanged.
- rx_ack with no completion in the same cycle clears rx_status and overrun. rx_data and the error flags keep their values.
- rx_ack while rx_status = 0 has no effect.
- A character with errors is still delivered. A break (all zeros, stop bit low) delivers rx_data = 0 with frame_err = 1.
- rx_en is checked only in IDLE. Dropping it mid-frame lets the current frame finish.

## Timing
- Reset state: every output is 0 and the FSM is in IDLE.
- Counter widths: tick counter $clog2(OVERSAMPLE); bit counter $clog2(DATA_BITS+1). The tick counter wraps to 0 at each sample point.
- Latency from the line edge to start detection is 2 sysclk (synchronizer) plus up to one tick period.
- rx_status rises exactly 1 sysclk after the tick carrying the last stop sample.
- reset low mid-frame aborts the frame on the next sysclk edge, and nothing is delivered.
- baud_tick held at 0 freezes the FSM and counters. The rx_ack path still operates.

## Structure
- Package uart_pkg holds:
  - the state enum uart_rx_state_t (IDLE, START, DATA, PARITY, STOP)
  - the parity-mode constants
  - the STOP_BITS legal-value check
- Sub-module uart_sync2 is the 2-flop synchronizer with a reset value parameter. It is reused by the transmitter's CTS input.
- Everything else stays in uart_rx_param.

## Test plan
- 8N1, OVERSAMPLE = 16: send 0xA5, then pulse rx_ack → rx_data = 0xA5 with no error flags, and rx_status = 1 until the ack.
- 8E1: send 0x03 with parity bit 1 → parity_err = 1, rx_data = 0x03. Resend with parity bit 0 → parity_err = 0.
- Line low for 5 ticks and then high → FSM returns to IDLE and rx_status stays 0.
- Send 0x11 then 0x22 with no ack → rx_data = 0x11 and overrun = 1. Then ack, send 0x33, and ack in the completion cycle of a further 0x44 → rx_data = 0x44, rx_status = 1, overrun = 0.
- DATA_BITS = 7, STOP_BITS = 2, second stop bit low on 0x55 → rx_data = 0x55 and frame_err = 1. A break gives rx_data = 0 and frame_err = 1.
- Assert reset low during the DATA state of 0x7E → all outputs 0 and nothing delivered. The next frame 0x81 is received cleanly.
